credit_receiver: RTL and testbench
==================================

Name: credit_receiver

Overview:
- Downstream receive stage paired with the upstream credit counter in the latency-insensitive channel.
- Buffers tokens sent under credit in an N_CREDITS-deep circular FIFO and presents them to the consumer with a valid/ready handshake.
- Emits one credit-return pulse per token consumed; this pulse drives the upstream counter's increment input.
- Flags any protocol overflow with a sticky error bit.

Parameters:
- DATA_WIDTH, 32, token payload width.
- N_CREDITS, 10, FIFO depth; must equal the upstream counter's credit count; minimum 1.
- RETURN_LATENCY, 1, register stages on the credit-return path; minimum 1.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream token present this cycle; sent only while upstream holds a credit.
- i_data  in  DATA_WIDTH  upstream token payload.
- o_valid  out  1  FIFO non-empty; head token on o_data.
- o_data  out  DATA_WIDTH  head-of-FIFO payload (show-ahead).
- i_ready  in  1  consumer accepts head token.
- o_credit_return  out  1  one-cycle pulse; one credit returned upstream.
- o_count  out  $clog2(N_CREDITS+1)  current occupancy.
- o_overflow  out  1  sticky: a push was attempted while full.

Behaviour:
- Definitions: push = i_valid; pop = o_valid & i_ready.
- Storage: N_CREDITS x DATA_WIDTH array; write pointer, read pointer, count.
  - Pointers wrap from N_CREDITS-1 to 0; N_CREDITS need not be a power of 2.
- Asynchronous reset (reset_n low):
  - Pointers = 0, count = 0.
  - o_valid = 0, o_count = 0, o_overflow = 0.
  - Credit pipe cleared, so o_credit_return = 0.
  - Memory contents are don't-care.
  - Reset mid-operation discards stored tokens and in-flight credits. The upstream counter is reset in the same domain and reloads N_CREDITS, so the system is consistent.
  - reset_n deassertion is synchronised to clock outside this block.
- Push:
  - Writes i_data at wr_ptr; wr_ptr advances.
  - The token is visible on o_data/o_valid the cycle after the push edge. There is no same-cycle bypass, so empty-to-valid latency is 1 cycle.
- Pop:
  - Read pointer advances; o_data is combinationally mem[rd_ptr].
  - o_data is don't-care while o_valid = 0.
- Count: count_next = count + push_accepted - pop.
  - Simultaneous push and pop leaves count unchanged.
  - o_valid = (count != 0); it is registered state, not a function of inputs.
- Full (count == N_CREDITS):
  - Push with pop in the same cycle: accepted. The freed slot is reused; count stays N_CREDITS.
  - Push without pop: data dropped, no pointer or count change, o_overflow set.
  - o_overflow holds until reset.
- Empty: pop is impossible (o_valid = 0); i_ready is ignored.
- Credit return:
  - Each pop enters a RETURN_LATENCY-deep shift register.
  - o_credit_return pulses exactly RETURN_LATENCY cycles after the pop edge.
  - Exactly one pulse per pop; back-to-back pops give back-to-back pulses.
  - No coalescing and no loss.
- Invariant while o_overflow = 0: count + credits in the return pipe + upstream credits = N_CREDITS.

Decomposition:
- Package lid_pkg:
  - Function/localparam for counter width ($clog2(N+1)).
  - Pointer width ($clog2(N), min 1).
  - Parameter checks: N_CREDITS >= 1, RETURN_LATENCY >= 1.
- Sub-module credit_return_pipe:
  - Parameterised 1-bit shift register, depth RETURN_LATENCY, asynchronous active-low reset.
  - Reusable on other LID channels.

Test Plan:
- Reset then idle: reset_n low 3 cycles with i_valid = 1 → o_valid = 0, o_count = 0, o_credit_return = 0, o_overflow = 0 throughout. After release with i_valid = 0 → all outputs stay 0.
- Single token, RETURN_LATENCY = 1:
  - Push 0xA5A5A5A5 at cycle 0 → cycle 1: o_valid = 1, o_data = 0xA5A5A5A5, o_count = 1.
  - i_ready = 1 at cycle 1 → cycle 2: o_valid = 0, o_credit_return = 1 for exactly one cycle.
- Fill and wrap, N_CREDITS = 10, i_ready = 0:
  - Push 1..10 → o_count = 10.
  - Then drain with i_ready = 1 → o_data sequence 1..10; exactly 10 credit pulses.
  - Repeat 3 times to exercise pointer wrap.
- Full with simultaneous push/pop: count = 10, push 11 with i_ready = 1 → o_count stays 10, o_overflow = 0, head advances to 2, tail holds 11.
- Overflow: count = 10, i_ready = 0, push 0xDEAD → o_overflow = 1 sticky, o_count = 10, contents unchanged. Cleared only by reset_n.
- Mid-operation reset, RETURN_LATENCY = 3:
  - Count = 4 with 2 credits in flight, assert reset_n asynchronously mid-cycle.
  - → outputs 0 immediately, no credit pulse after release, next push seen 1 cycle later at o_count = 1.

Source files
------------

// File: rtl/lid_pkg.sv
// rtl/lid_pkg.sv - shared sizing helpers for latency-insensitive channel blocks
//
// Purpose: width helpers and parameter sanity check used by the credit
// receiver and other LID channel blocks.
// Ports: none (package).

package lid_pkg;

  // Width needed to hold the values 0..n inclusive (occupancy counters).
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Width needed to address n slots; never narrower than one bit so a
  // single-entry FIFO still has a legal pointer.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int n_credits, input int return_latency);
    return (n_credits >= 1) && (return_latency >= 1);
  endfunction

endpackage

// File: rtl/credit_return_pipe.sv
// rtl/credit_return_pipe.sv - fixed-latency one-bit pulse delay line
//
// Purpose: delays each credit-return pulse by DEPTH clock cycles without
// merging or dropping pulses; reusable on any LID channel.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset, clears all stages
//   i_pulse  in   pulse entering the pipe
//   o_pulse  out  pulse leaving the pipe, DEPTH cycles later

module credit_return_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_pulse,
  output logic o_pulse
);

  logic [DEPTH-1:0] stages;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          stages <= '0;
        end else begin
          stages <= i_pulse;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          stages <= '0;
        end else begin
          stages <= {stages[DEPTH-2:0], i_pulse};
        end
      end
    end
  endgenerate

  assign o_pulse = stages[DEPTH-1];

endmodule

// File: rtl/credit_receiver.sv
// rtl/credit_receiver.sv - credit-based receive FIFO with credit-return pulses
//
// Purpose: buffers tokens sent under credit in an N_CREDITS-deep circular
// FIFO, presents them show-ahead with valid/ready, returns one credit per
// consumed token after RETURN_LATENCY cycles, and flags overflow stickily.
// Ports:
//   clock            in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   i_valid          in   upstream token present (push)
//   i_data           in   upstream token payload
//   o_valid          out  FIFO non-empty
//   o_data           out  head-of-FIFO payload, don't-care while o_valid = 0
//   i_ready          in   consumer takes the head token
//   o_credit_return  out  one-cycle pulse per consumed token
//   o_count          out  current occupancy
//   o_overflow       out  sticky: push attempted while full without a pop

module credit_receiver
  import lid_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int N_CREDITS      = 10,
  parameter int RETURN_LATENCY = 1
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   i_valid,
  input  logic [DATA_WIDTH-1:0]                  i_data,
  output logic                                   o_valid,
  output logic [DATA_WIDTH-1:0]                  o_data,
  input  logic                                   i_ready,
  output logic                                   o_credit_return,
  output logic [lid_pkg::count_width(N_CREDITS)-1:0] o_count,
  output logic                                   o_overflow
);

  localparam int CW = count_width(N_CREDITS);
  localparam int PW = ptr_width(N_CREDITS);

  generate
    if (!params_ok(N_CREDITS, RETURN_LATENCY)) begin : g_param_check
      $error("credit_receiver: N_CREDITS and RETURN_LATENCY must both be >= 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [N_CREDITS];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;

  logic full;
  logic pop;
  logic push_accepted;
  logic push_dropped;

  // Pointers wrap explicitly because N_CREDITS need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(N_CREDITS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full          = (count == CW'(N_CREDITS));
  assign pop           = o_valid & i_ready;
  // When full, a same-cycle pop frees the slot the push will reuse.
  assign push_accepted = i_valid & (~full | pop);
  assign push_dropped  = i_valid & full & ~pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_accepted) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push_accepted && !pop) begin
        count <= count + CW'(1);
      end else if (!push_accepted && pop) begin
        count <= count - CW'(1);
      end
      if (push_dropped) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; stale entries are never visible since o_valid
  // follows the reset count.
  always_ff @(posedge clock) begin
    if (push_accepted) begin
      mem[wr_ptr] <= i_data;
    end
  end

  assign o_valid    = (count != '0);
  assign o_data     = mem[rd_ptr];
  assign o_count    = count;
  assign o_overflow = overflow;

  credit_return_pipe #(
    .DEPTH (RETURN_LATENCY)
  ) u_credit_return_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_pulse (pop),
    .o_pulse (o_credit_return)
  );

endmodule

// File: tb/tb_credit_receiver.sv
// tb/tb_credit_receiver.sv - self-checking bench for credit_receiver

module tb_credit_receiver;

  localparam int DW = 32;
  localparam int N  = 10;

  logic          clock;
  logic          reset_n;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_ready;

  logic          v1, v3, cr1, cr3, of1, of3;
  logic [DW-1:0] d1, d3;
  logic [3:0]    c1, c3;

  credit_receiver #(.DATA_WIDTH(DW), .N_CREDITS(N), .RETURN_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
    .o_valid(v1), .o_data(d1), .i_ready(i_ready), .o_credit_return(cr1),
    .o_count(c1), .o_overflow(of1)
  );

  credit_receiver #(.DATA_WIDTH(DW), .N_CREDITS(N), .RETURN_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data),
    .o_valid(v3), .o_data(d3), .i_ready(i_ready), .o_credit_return(cr3),
    .o_count(c3), .o_overflow(of3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: token queue, sticky overflow, and a record of which
  // recent clock edges consumed a token (bit k = k edges before the latest).
  logic [DW-1:0] mq[$];
  bit            movf;
  bit [7:0]      hist;
  bit            m_pop;
  bit            m_full;

  always @(negedge reset_n) begin
    mq.delete();
    movf = 0;
    hist = '0;
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      mq.delete();
      movf = 0;
      hist = '0;
    end else begin
      m_pop  = (mq.size() != 0) && i_ready;
      m_full = (mq.size() == N);
      if (m_pop) void'(mq.pop_front());
      if (i_valid) begin
        if (!m_full || m_pop) mq.push_back(i_data);
        else movf = 1;
      end
      hist = {hist[6:0], m_pop};
    end
  end

  int cr1_total = 0;
  int cr3_total = 0;

  always @(negedge clock) begin
    if (cr1) cr1_total++;
    if (cr3) cr3_total++;
    chk("valid_l1", v1, mq.size() != 0);
    chk("valid_l3", v3, mq.size() != 0);
    chk("count_l1", c1, mq.size());
    chk("count_l3", c3, mq.size());
    chk("ovf_l1", of1, movf);
    chk("ovf_l3", of3, movf);
    chk("credit_l1", cr1, hist[0]);
    chk("credit_l3", cr3, hist[2]);
    if (mq.size() != 0) begin
      chk("data_l1", d1, mq[0]);
      chk("data_l3", d3, mq[0]);
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    @(posedge clock);
    #1;
  endtask

  int s;

  initial begin
    reset_n = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h1234_5678;
    i_ready = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    chk("rst_valid", v1, 1'b0);
    chk("rst_count", c1, 0);
    chk("rst_ovf", of1, 1'b0);
    reset_n = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("idle_valid", v1, 1'b0);
    chk("idle_credit", cr1, 1'b0);

    // Single token
    cyc(1, 32'hA5A5_A5A5, 0);
    chk("one_valid", v1, 1'b1);
    chk("one_data", d1, 32'hA5A5_A5A5);
    chk("one_count", c1, 1);
    cyc(0, 0, 1);
    chk("one_popped", v1, 1'b0);
    chk("one_credit", cr1, 1'b1);
    cyc(0, 0, 0);
    chk("one_credit_end", cr1, 1'b0);
    chk("one_credit3_early", cr3, 1'b0);
    cyc(0, 0, 0);
    chk("one_credit3", cr3, 1'b1);
    cyc(0, 0, 0);

    // Fill and drain three times to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= N; k++) cyc(1, k, 0);
      chk("fill_count", c1, N);
      s = cr1_total;
      for (int k = 1; k <= N; k++) begin
        chk("drain_head", d1, k);
        cyc(0, 0, 1);
      end
      cyc(0, 0, 0);
      chk("drain_credits", cr1_total - s, N);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
    end

    // Full with simultaneous push and pop
    for (int k = 1; k <= N; k++) cyc(1, k, 0);
    cyc(1, 11, 1);
    chk("fullpp_count", c1, N);
    chk("fullpp_ovf", of1, 1'b0);
    chk("fullpp_head", d1, 2);
    for (int k = 2; k <= 11; k++) begin
      chk("fullpp_drain", d1, k);
      cyc(0, 0, 1);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // Overflow
    for (int k = 21; k <= 30; k++) cyc(1, k, 0);
    cyc(1, 32'hDEAD, 0);
    chk("ovf_set", of1, 1'b1);
    chk("ovf_count", c1, N);
    chk("ovf_head", d1, 21);
    for (int k = 21; k <= 30; k++) begin
      chk("ovf_drain", d1, k);
      cyc(0, 0, 1);
    end
    cyc(0, 0, 0);
    chk("ovf_sticky", of1, 1'b1);
    chk("ovf_empty", c1, 0);

    // Mid-operation asynchronous reset with credits in flight
    for (int k = 0; k < 6; k++) cyc(1, 40 + k, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("mid_count3", c3, 4);
    chk("mid_credit3", cr3, 1'b0);
    i_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", v3, 1'b0);
    chk("mid_rst_count", c3, 0);
    chk("mid_rst_ovf", of3, 1'b0);
    chk("mid_rst_credit", cr3, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    s = cr3_total;
    repeat (5) cyc(0, 0, 0);
    chk("mid_no_credit", cr3_total - s, 0);
    cyc(1, 77, 0);
    chk("post_count", c3, 1);
    chk("post_data", d3, 77);
    cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
